game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
- Top-level game sequencer for the obstacle game.
- Turns the player's go button, the collision flag and the per-frame tick into the control strobes consumed by the minutes/seconds timer display: run enable, flash enable, flash clock and timer clear.
- Also gates obstacle/player motion through game_run.
- Sits directly upstream of the timer display and alongside the obstacle movers.

Parameters:
- READY_FRAMES, 120, frames spent in READY (2 s at 60 Hz) before play begins.
- FLASH_FRAMES, 15, frames per half-period of f_clk.
- CNT_W, 8, width of frame counters; must hold max(READY_FRAMES, FLASH_FRAMES).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- go_btn  in  1  go button, already synchronized/debounced, level.
- collide  in  1  level, high while player overlaps an obstacle.
- frame  in  1  one-cycle pulse once per video frame.
- start  out  1  timer run enable; high only in PLAY.
- flash  out  1  timer flash enable; high in READY and OVER.
- f_clk  out  1  flash phase; toggles every FLASH_FRAMES frames while flash=1, else 0.
- timer_clr  out  1  one-cycle pulse clearing the timer; top level ORs it with reset.
- game_run  out  1  motion enable for obstacles/player; high only in PLAY.
- state  out  2  current state encoding, for debug LEDs.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - Port names are clk and reset.
- Reset values:
  - state=IDLE(00); start, flash, f_clk, timer_clr and game_run are all 0.
  - Both counters are 0; go_q is 0.
- Outputs are registered. A transition caused by an input sampled at edge N is visible at the outputs after edge N+1.
- Button edge:
  - go_pulse = go_btn & ~go_q, where go_q is go_btn registered.
  - Holding the button produces exactly one go_pulse.
- States: IDLE=00, READY=01, PLAY=10, OVER=11.
- IDLE:
  - Outputs: start=0, flash=0, game_run=0.
  - go_pulse -> READY; timer_clr=1 for one cycle; ready_cnt=0; flash_cnt=0; f_clk=1.
- READY:
  - Outputs: flash=1, start=0, game_run=0.
  - Each frame increments ready_cnt.
  - A frame arriving while ready_cnt==READY_FRAMES-1 -> PLAY, ready_cnt=0.
  - collide and go_pulse are ignored.
- PLAY:
  - Outputs: start=1, game_run=1, flash=0, f_clk=0.
  - collide=1 -> OVER; flash_cnt=0; f_clk=1.
  - go_pulse is ignored.
- OVER:
  - Outputs: start=0, game_run=0, flash=1. The timer holds its final value (no timer_clr).
  - go_pulse -> READY with timer_clr pulse, as from IDLE.
- f_clk (READY and OVER only):
  - Each frame increments flash_cnt.
  - A frame arriving while flash_cnt==FLASH_FRAMES-1 toggles f_clk and sets flash_cnt=0.
  - f_clk is 0 in IDLE and PLAY.
- Simultaneous events and boundaries:
  - collide and go_pulse in the same cycle in PLAY: collide wins.
  - frame on the same cycle as a state-changing event: the state transition wins; the counters take their entry values.
  - reset in any state or mid-count overrides everything and returns to reset values on the next edge; timer_clr is not pulsed by reset.
  - frame pulses closer than one cycle are not supported; each counts once.
  - Counters never wrap: they are cleared on reaching terminal, so CNT_W overflow is impossible with legal parameters.
- timer_clr is exactly one cycle wide and is never asserted in two consecutive cycles.

Decomposition:
- Shared package game_pkg holds:
  - state typedef/localparams IDLE, READY, PLAY, OVER;
  - default READY_FRAMES=120 and FLASH_FRAMES=15;
  - FRAME_HZ=60.
- One natural sub-module: frame_divider (CNT_W, TERMINAL).
  - Inputs: clk, reset, clr, frame.
  - Output: done, a one-cycle pulse on the terminal frame.
  - Instantiate twice: ready timer and flash timer.

Test Plan:
- Reset then idle 10 frames -> state=00; start=0; flash=0; f_clk=0; timer_clr never high.
- go_btn held high 50 cycles from IDLE -> exactly one timer_clr pulse; state=01, flash=1, f_clk=1. After frame #15, f_clk=0. After frame #120, state=10, start=1, game_run=1, flash=0.
- In PLAY, collide=1 together with go_btn rising -> state=11, start=0, flash=1, f_clk=1, no timer_clr. f_clk toggles after every 15 frames (check 4 toggles over 60 frames).
- In OVER, go_btn rising -> timer_clr one cycle; state=01. collide=1 held throughout READY -> still reaches PLAY after 120 frames.
- reset asserted at READY frame 60 -> next edge all outputs 0, state=00. A new go gives the full 120-frame READY (no residual count).
- Reduced parameters READY_FRAMES=1, FLASH_FRAMES=1 -> PLAY entered on the first frame after go. f_clk toggles on every frame in OVER.

Source files
------------

// File: rtl/game_pkg.sv
// Shared state encodings and default timing for the obstacle-game sequencer.
// No logic here: constants only.
// No handshaking: constants only.
package game_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] READY = 2'b01;
    localparam logic [1:0] PLAY  = 2'b10;
    localparam logic [1:0] OVER  = 2'b11;

    localparam int FRAME_HZ         = 60;
    localparam int DEF_READY_FRAMES = 2 * FRAME_HZ;
    localparam int DEF_FLASH_FRAMES = 15;

endpackage

// File: rtl/game_ctrl_frame_divider.sv
// Counts frame pulses and flags the TERMINAL-th one, then restarts from zero.
// done is combinational from frame and the count: same cycle as the terminal frame.
// No backpressure; clr has priority over frame and suppresses done.
module frame_divider #(
    parameter int CNT_W    = 8,
    parameter int TERMINAL = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic frame,
    output logic done
);

    localparam logic [CNT_W-1:0] TERM_M1 = CNT_W'(TERMINAL - 1);

    logic [CNT_W-1:0] cnt;
    logic             at_term;

    assign at_term = (cnt == TERM_M1);
    assign done    = frame & at_term & ~clr;

    // Frame counter: cleared on terminal so it never wraps through CNT_W.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (frame) begin
            cnt <= at_term ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: IDLE/READY/PLAY/OVER driving timer strobes and motion enable.
// Inputs are registered once, state/outputs once more: input at edge N shows after edge N+1.
// No backpressure; frame pulses must be at least one idle cycle apart.
module game_ctrl
    import game_pkg::*;
#(
    parameter int READY_FRAMES = DEF_READY_FRAMES,
    parameter int FLASH_FRAMES = DEF_FLASH_FRAMES,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go_btn,
    input  logic       collide,
    input  logic       frame,
    output logic       start,
    output logic       flash,
    output logic       f_clk,
    output logic       timer_clr,
    output logic       game_run,
    output logic [1:0] state
);

    logic   go_q;
    logic   go_pulse;
    logic   go_evt_r;
    logic   frame_r;
    logic   collide_r;

    state_t state_nxt;
    logic   fclk_nxt;
    logic   clr_nxt;

    logic   flashing;
    logic   restart;
    logic   ready_done;
    logic   flash_done;

    // Rising edge of the level button: one pulse per press however long it is held.
    assign go_pulse = go_btn & ~go_q;

    // Input stage: edge detector history plus one register on every event.
    always_ff @(posedge clk) begin
        if (reset) begin
            go_q      <= 1'b0;
            go_evt_r  <= 1'b0;
            frame_r   <= 1'b0;
            collide_r <= 1'b0;
        end else begin
            go_q      <= go_btn;
            go_evt_r  <= go_pulse;
            frame_r   <= frame;
            collide_r <= collide;
        end
    end

    assign flashing = (state == READY) || (state == OVER);
    assign restart  = go_evt_r && ((state == IDLE) || (state == OVER));

    // Ready timer only counts in READY and is held at zero everywhere else,
    // so every entry into READY starts a full countdown.
    frame_divider #(
        .CNT_W    (CNT_W),
        .TERMINAL (READY_FRAMES)
    ) u_ready_div (
        .clk   (clk),
        .reset (reset),
        .clr   (state != READY),
        .frame (frame_r && (state == READY)),
        .done  (ready_done)
    );

    // Flash timer runs in READY and OVER; a restart from OVER re-phases it.
    frame_divider #(
        .CNT_W    (CNT_W),
        .TERMINAL (FLASH_FRAMES)
    ) u_flash_div (
        .clk   (clk),
        .reset (reset),
        .clr   (!flashing || restart),
        .frame (frame_r && flashing),
        .done  (flash_done)
    );

    // Next-state and next-output decode; a state change beats a flash toggle.
    always_comb begin
        state_nxt = state;
        fclk_nxt  = f_clk;
        clr_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (go_evt_r) begin
                    state_nxt = READY;
                    clr_nxt   = 1'b1;
                    fclk_nxt  = 1'b1;
                end
            end
            READY: begin
                if (ready_done) begin
                    state_nxt = PLAY;
                    fclk_nxt  = 1'b0;
                end else if (flash_done) begin
                    fclk_nxt = ~f_clk;
                end
            end
            PLAY: begin
                if (collide_r) begin
                    state_nxt = OVER;
                    fclk_nxt  = 1'b1;
                end
            end
            OVER: begin
                if (go_evt_r) begin
                    state_nxt = READY;
                    clr_nxt   = 1'b1;
                    fclk_nxt  = 1'b1;
                end else if (flash_done) begin
                    fclk_nxt = ~f_clk;
                end
            end
            default: begin
                state_nxt = IDLE;
                fclk_nxt  = 1'b0;
            end
        endcase
    end

    // State and all strobes registered together so outputs are glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            start     <= 1'b0;
            game_run  <= 1'b0;
            flash     <= 1'b0;
            f_clk     <= 1'b0;
            timer_clr <= 1'b0;
        end else begin
            state     <= state_nxt;
            start     <= (state_nxt == PLAY);
            game_run  <= (state_nxt == PLAY);
            flash     <= (state_nxt == READY) || (state_nxt == OVER);
            f_clk     <= fclk_nxt;
            timer_clr <= clr_nxt;
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with a scoreboard of expected output snapshots.
module tb_game_ctrl;
    import game_pkg::*;

    logic       clk;
    logic       reset;
    logic       go_btn;
    logic       collide;
    logic       frame;

    logic       start, flash, f_clk, timer_clr, game_run;
    logic [1:0] state;
    logic       m_start, m_flash, m_f_clk, m_timer_clr, m_game_run;
    logic [1:0] m_state;

    int n_cmp = 0;
    int n_bad = 0;
    int clr_cnt = 0;
    int consec = 0;
    logic clr_prev = 1'b0;

    typedef struct packed {
        logic       sel;
        logic [1:0] st;
        logic       start;
        logic       flash;
        logic       fclk;
        logic       run;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    game_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .go_btn    (go_btn),
        .collide   (collide),
        .frame     (frame),
        .start     (start),
        .flash     (flash),
        .f_clk     (f_clk),
        .timer_clr (timer_clr),
        .game_run  (game_run),
        .state     (state)
    );

    game_ctrl #(
        .READY_FRAMES (1),
        .FLASH_FRAMES (1),
        .CNT_W        (8)
    ) dut_min (
        .clk       (clk),
        .reset     (reset),
        .go_btn    (go_btn),
        .collide   (collide),
        .frame     (frame),
        .start     (m_start),
        .flash     (m_flash),
        .f_clk     (m_f_clk),
        .timer_clr (m_timer_clr),
        .game_run  (m_game_run),
        .state     (m_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count timer_clr pulses of the default instance and any back-to-back pair.
    always @(negedge clk) begin
        if (timer_clr) begin
            clr_cnt <= clr_cnt + 1;
            if (clr_prev) consec <= consec + 1;
        end
        clr_prev <= timer_clr;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One frame pulse followed by enough idle cycles for the result to settle.
    task automatic do_frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame = 1'b1;
            @(negedge clk);
            frame = 1'b0;
            tick(2);
        end
    endtask

    task automatic push(input string tag, input logic sel, input logic [1:0] st,
                        input logic s, input logic fl, input logic fc, input logic run);
        exp_t e;
        e.sel   = sel;
        e.st    = st;
        e.start = s;
        e.flash = fl;
        e.fclk  = fc;
        e.run   = run;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic sb_check();
        exp_t       e;
        string      t;
        logic [1:0] o_st;
        logic       o_s, o_fl, o_fc, o_run;
        chk("sb_depth", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            o_st  = e.sel ? m_state    : state;
            o_s   = e.sel ? m_start    : start;
            o_fl  = e.sel ? m_flash    : flash;
            o_fc  = e.sel ? m_f_clk    : f_clk;
            o_run = e.sel ? m_game_run : game_run;
            chk({t, ".state"},    int'(o_st),  int'(e.st));
            chk({t, ".start"},    int'(o_s),   int'(e.start));
            chk({t, ".flash"},    int'(o_fl),  int'(e.flash));
            chk({t, ".f_clk"},    int'(o_fc),  int'(e.fclk));
            chk({t, ".game_run"}, int'(o_run), int'(e.run));
        end
    endtask

    initial begin
        reset   = 1'b1;
        go_btn  = 1'b0;
        collide = 1'b0;
        frame   = 1'b0;

        // Reset state and a quiet IDLE.
        push("reset", 0, IDLE, 0, 0, 0, 0);
        tick(3);
        sb_check();
        chk("reset.timer_clr", int'(timer_clr), 0);
        reset = 1'b0;
        push("idle10", 0, IDLE, 0, 0, 0, 0);
        do_frames(10);
        sb_check();
        chk("idle.clr_cnt", clr_cnt, 0);

        // Held button: one clear pulse, READY with flashing.
        push("go_held", 0, READY, 0, 1, 1, 0);
        go_btn = 1'b1;
        tick(50);
        sb_check();
        chk("go_held.clr_cnt", clr_cnt, 1);
        go_btn = 1'b0;
        tick(2);
        push("ready_f14", 0, READY, 0, 1, 1, 0);
        do_frames(14);
        sb_check();
        push("ready_f15", 0, READY, 0, 1, 0, 0);
        do_frames(1);
        sb_check();
        push("ready_f119", 0, READY, 0, 1, 0, 0);
        do_frames(104);
        sb_check();
        push("ready_f120", 0, PLAY, 1, 0, 0, 1);
        do_frames(1);
        sb_check();
        push("play_frames", 0, PLAY, 1, 0, 0, 1);
        do_frames(5);
        sb_check();

        // Collide and button together in PLAY: collide wins, no clear.
        push("collide_go", 0, OVER, 0, 1, 1, 0);
        collide = 1'b1;
        go_btn  = 1'b1;
        tick(4);
        sb_check();
        chk("collide_go.clr_cnt", clr_cnt, 1);
        collide = 1'b0;
        go_btn  = 1'b0;
        tick(2);
        for (int k = 0; k < 4; k++) begin
            push($sformatf("over_tgl%0d", k), 0, OVER, 0, 1, logic'(k % 2), 0);
            do_frames(15);
            sb_check();
        end

        // Restart from OVER with collide held through READY.
        push("over_go", 0, READY, 0, 1, 1, 0);
        go_btn = 1'b1;
        tick(4);
        sb_check();
        chk("over_go.clr_cnt", clr_cnt, 2);
        go_btn  = 1'b0;
        collide = 1'b1;
        push("coll_ready_f119", 0, READY, 0, 1, 0, 0);
        do_frames(119);
        sb_check();
        push("coll_ready_f120", 0, PLAY, 1, 0, 0, 1);
        @(negedge clk);
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        @(negedge clk);
        sb_check();
        push("coll_play_over", 0, OVER, 0, 1, 1, 0);
        @(negedge clk);
        sb_check();
        collide = 1'b0;
        tick(2);

        // Reset in the middle of a READY count, then a full fresh countdown.
        push("pre_reset_go", 0, READY, 0, 1, 1, 0);
        go_btn = 1'b1;
        tick(4);
        sb_check();
        go_btn = 1'b0;
        push("ready_f60", 0, READY, 0, 1, 1, 0);
        do_frames(60);
        sb_check();
        push("reset_mid", 0, IDLE, 0, 0, 0, 0);
        reset = 1'b1;
        tick(1);
        sb_check();
        chk("reset_mid.timer_clr", int'(timer_clr), 0);
        reset = 1'b0;
        tick(2);
        chk("reset_mid.clr_cnt", clr_cnt, 3);
        push("rego", 0, READY, 0, 1, 1, 0);
        go_btn = 1'b1;
        tick(4);
        sb_check();
        go_btn = 1'b0;
        chk("rego.clr_cnt", clr_cnt, 4);
        push("rego_f119", 0, READY, 0, 1, 0, 0);
        do_frames(119);
        sb_check();
        push("rego_f120", 0, PLAY, 1, 0, 0, 1);
        do_frames(1);
        sb_check();
        chk("clr_back_to_back", consec, 0);

        // Minimal terminals: every frame is terminal.
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        push("min_go", 1, READY, 0, 1, 1, 0);
        go_btn = 1'b1;
        tick(4);
        sb_check();
        go_btn = 1'b0;
        push("min_f1", 1, PLAY, 1, 0, 0, 1);
        do_frames(1);
        sb_check();
        push("min_over", 1, OVER, 0, 1, 1, 0);
        collide = 1'b1;
        tick(4);
        sb_check();
        collide = 1'b0;
        chk("min_over.timer_clr", int'(m_timer_clr), 0);
        push("min_tgl0", 1, OVER, 0, 1, 0, 0);
        do_frames(1);
        sb_check();
        push("min_tgl1", 1, OVER, 0, 1, 1, 0);
        do_frames(1);
        sb_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
